// File: rtl/pucch_cs_hop_gen.sv
// PUCCH cyclic-shift hopping generator: drives c_seq_gen with c_init = n_ID, discards
// earlier-slot PRBS bits, then packs one n_cs byte per symbol and emits (m0+m_cs+n_cs) mod 12.
module pucch_cs_hop_gen #(
  parameter int nGenBit   = 8,
  parameter int nSlotSymb = 14,
  parameter int MaxSlot   = 159
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [9:0]         i_nid,
  input  logic [7:0]         i_nslot,
  input  logic [3:0]         i_m0,
  input  logic [3:0]         i_mcs,
  output logic               o_prbs_en,
  output logic               o_prbs_load,
  output logic [30:0]        o_prbs_init,
  input  logic [nGenBit-1:0] i_prbs_bit,
  input  logic               i_prbs_valid,
  output logic [7:0]         o_ncs,
  output logic [3:0]         o_cs_idx,
  output logic [3:0]         o_sym_idx,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int WORDS_PER_SLOT = 8 * nSlotSymb / nGenBit;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SKIP    = 3'd2;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]  state;
  logic [9:0]  nid_q;
  logic [7:0]  nslot_q;
  logic [3:0]  m0_q, mcs_q;
  logic [14:0] skip_cnt;
  logic [14:0] skip_tgt;
  logic [3:0]  sym_cnt;
  logic        err_q, done_q, valid_q;
  logic [7:0]  ncs_q;
  logic [3:0]  cs_q, sym_q;

  logic        take;
  logic        byte_done;
  logic [7:0]  byte_val;
  logic [8:0]  cs_sum;
  logic [3:0]  cs_next;
  logic        bad_req;

  assign take     = (state == S_COLLECT) && i_prbs_valid;
  assign skip_tgt = 15'(nslot_q) * 15'(WORDS_PER_SLOT);
  assign cs_sum   = 9'(m0_q) + 9'(mcs_q) + 9'(byte_val);
  assign cs_next  = 4'(cs_sum % 9'd12);
  assign bad_req  = (i_nslot > 8'(MaxSlot)) || (i_m0 > 4'd11) || (i_mcs > 4'd11);

  // Byte assembly: a full word per byte, or eight serial bits with the first bit as LSB.
  generate
    if (nGenBit == 8) begin : g_word
      assign byte_val  = i_prbs_bit[7:0];
      assign byte_done = take;
    end else begin : g_bit
      logic [6:0] sr;
      logic [2:0] bit_cnt;
      assign byte_val  = {i_prbs_bit[0], sr};
      assign byte_done = take && (bit_cnt == 3'd7);
      always_ff @(posedge clk) begin
        if (rst || state == S_LOAD) begin
          sr      <= '0;
          bit_cnt <= '0;
        end else if (take) begin
          sr      <= byte_val[7:1];
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      nid_q    <= '0;
      nslot_q  <= '0;
      m0_q     <= '0;
      mcs_q    <= '0;
      skip_cnt <= '0;
      sym_cnt  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      ncs_q    <= '0;
      cs_q     <= '0;
      sym_q    <= '0;
    end else begin
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= (state == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (i_start) begin
            nid_q   <= i_nid;
            nslot_q <= i_nslot;
            m0_q    <= i_m0;
            mcs_q   <= i_mcs;
            if (bad_req) err_q <= 1'b1;
            else         state <= S_LOAD;
          end
        end
        S_LOAD: begin
          skip_cnt <= '0;
          sym_cnt  <= '0;
          state    <= (nslot_q == 8'd0) ? S_COLLECT : S_SKIP;
        end
        S_SKIP: begin
          if (i_prbs_valid) begin
            if (skip_cnt == skip_tgt - 15'd1) begin
              skip_cnt <= '0;
              state    <= S_COLLECT;
            end else begin
              skip_cnt <= skip_cnt + 15'd1;
            end
          end
        end
        S_COLLECT: begin
          if (byte_done) begin
            valid_q <= 1'b1;
            ncs_q   <= byte_val;
            cs_q    <= cs_next;
            sym_q   <= sym_cnt;
            // Leaving here drops the enable on the same edge, so no word past the slot is taken.
            if (sym_cnt == 4'(nSlotSymb - 1)) state <= S_DONE;
            else                               sym_cnt <= sym_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_prbs_en   = (state == S_LOAD) || (state == S_SKIP) || (state == S_COLLECT);
  assign o_busy      = o_prbs_en;
  assign o_prbs_load = (state == S_LOAD);
  assign o_prbs_init = (state == S_LOAD) ? {21'b0, nid_q} : 31'd0;
  assign o_ncs       = ncs_q;
  assign o_cs_idx    = cs_q;
  assign o_sym_idx   = sym_q;
  assign o_valid     = valid_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_pucch_cs_hop_gen.sv
// Scoreboard bench: word-wide and bit-serial instances share control inputs; each has its own
// Gold-sequence PRBS source and expected-output queue filled from a TS 38.211 reference model.
module tb_pucch_cs_hop_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, i_start;
  logic [9:0] i_nid;
  logic [7:0] i_nslot;
  logic [3:0] i_m0, i_mcs;

  logic        a_en, a_load, a_pv, a_valid, a_busy, a_done, a_err;
  logic [30:0] a_init;
  logic [7:0]  a_bit, a_ncs;
  logic [3:0]  a_cs, a_sym;
  logic        b_en, b_load, b_pv, b_valid, b_busy, b_done, b_err;
  logic [30:0] b_init;
  logic [0:0]  b_bit;
  logic [7:0]  b_ncs;
  logic [3:0]  b_cs, b_sym;

  pucch_cs_hop_gen #(.nGenBit(8)) dut_a (
    .clk(clk), .rst(rst), .i_start(i_start), .i_nid(i_nid), .i_nslot(i_nslot),
    .i_m0(i_m0), .i_mcs(i_mcs), .o_prbs_en(a_en), .o_prbs_load(a_load),
    .o_prbs_init(a_init), .i_prbs_bit(a_bit), .i_prbs_valid(a_pv), .o_ncs(a_ncs),
    .o_cs_idx(a_cs), .o_sym_idx(a_sym), .o_valid(a_valid), .o_busy(a_busy),
    .o_done(a_done), .o_err(a_err));

  pucch_cs_hop_gen #(.nGenBit(1)) dut_b (
    .clk(clk), .rst(rst), .i_start(i_start), .i_nid(i_nid), .i_nslot(i_nslot),
    .i_m0(i_m0), .i_mcs(i_mcs), .o_prbs_en(b_en), .o_prbs_load(b_load),
    .o_prbs_init(b_init), .i_prbs_bit(b_bit), .i_prbs_valid(b_pv), .o_ncs(b_ncs),
    .o_cs_idx(b_cs), .o_sym_idx(b_sym), .o_valid(b_valid), .o_busy(b_busy),
    .o_done(b_done), .o_err(b_err));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference Gold sequence c(n), n = 0..len-1, for c_init = nid.
  bit cref[];
  bit ff_mode = 1'b0;
  int stall_pct = 30;

  task automatic gen_c(input int nid, input int len);
    int tot = len + 1631;
    bit x1[], x2[];
    x1 = new[tot];
    x2 = new[tot];
    for (int i = 0; i < 31; i++) begin
      x1[i] = (i == 0);
      x2[i] = nid[i];
    end
    for (int n = 0; n + 31 < tot; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    cref = new[len];
    for (int n = 0; n < len; n++) cref[n] = x1[n+1600] ^ x2[n+1600];
  endtask

  function automatic logic bit_at(input int pos);
    if (ff_mode) return 1'b1;
    return (pos < cref.size()) ? logic'(cref[pos]) : 1'b0;
  endfunction

  function automatic logic [7:0] word_at(input int pos);
    logic [7:0] w;
    for (int j = 0; j < 8; j++) w[j] = bit_at(pos + j);
    return w;
  endfunction

  // Behavioural c_seq_gen stand-ins with random valid gaps; they also count words taken.
  int a_pos = 0, a_cons = 0, b_pos = 0, b_cons = 0;
  always @(posedge clk) begin
    if (rst) begin
      a_pv <= 1'b0; a_bit <= '0;
    end else if (a_load) begin
      a_pos = 0; a_cons = 0; a_pv <= 1'b0;
    end else if (a_en) begin
      if (a_pv) a_cons++;
      if ($urandom_range(99) >= stall_pct) begin
        a_bit <= word_at(a_pos); a_pv <= 1'b1; a_pos += 8;
      end else a_pv <= 1'b0;
    end else a_pv <= 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      b_pv <= 1'b0; b_bit <= '0;
    end else if (b_load) begin
      b_pos = 0; b_cons = 0; b_pv <= 1'b0;
    end else if (b_en) begin
      if (b_pv) b_cons++;
      if ($urandom_range(99) >= stall_pct) begin
        b_bit <= bit_at(b_pos); b_pv <= 1'b1; b_pos += 1;
      end else b_pv <= 1'b0;
    end else b_pv <= 1'b0;
  end

  typedef struct {int ncs; int cs; int sym;} exp_t;
  exp_t qa[$], qb[$];
  bit a_done_seen, b_done_seen;
  int a_nvalid = 0;
  bit a_pv_prev = 0, b_pv_prev = 0, a_l13_prev = 0, b_l13_prev = 0;

  always @(negedge clk) begin
    exp_t e;
    if (a_valid) begin
      chk("a_valid_after_word", int'(a_pv_prev), 1);
      if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_ncs", int'(a_ncs), e.ncs);
        chk("a_cs_idx", int'(a_cs), e.cs);
        chk("a_sym_idx", int'(a_sym), e.sym);
      end
      a_nvalid++;
    end
    if (a_done) begin
      a_done_seen = 1;
      chk("a_done_after_l13", int'(a_l13_prev), 1);
      chk("a_done_busy", int'(a_busy), 0);
    end
    a_l13_prev = a_valid && (a_sym == 4'd13);
    a_pv_prev  = a_pv;
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_valid) begin
      chk("b_valid_after_word", int'(b_pv_prev), 1);
      if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_ncs", int'(b_ncs), e.ncs);
        chk("b_cs_idx", int'(b_cs), e.cs);
        chk("b_sym_idx", int'(b_sym), e.sym);
      end
    end
    if (b_done) begin
      b_done_seen = 1;
      chk("b_done_after_l13", int'(b_l13_prev), 1);
      chk("b_done_busy", int'(b_busy), 0);
    end
    b_l13_prev = b_valid && (b_sym == 4'd13);
    b_pv_prev  = b_pv;
  end

  task automatic expect_slot(input int nid, input int ns, input int m0, input int mcs);
    exp_t e;
    gen_c(nid, 112 * (ns + 1));
    for (int l = 0; l < 14; l++) begin
      e.ncs = 0;
      for (int m = 0; m < 8; m++) e.ncs |= int'(bit_at(112 * ns + 8 * l + m)) << m;
      e.cs  = (m0 + mcs + e.ncs) % 12;
      e.sym = l;
      qa.push_back(e);
      qb.push_back(e);
    end
  endtask

  task automatic issue(input int nid, input int ns, input int m0, input int mcs);
    @(negedge clk);
    i_start = 1'b1;
    i_nid = 10'(nid); i_nslot = 8'(ns); i_m0 = 4'(m0); i_mcs = 4'(mcs);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run(input int nid, input int ns, input int m0, input int mcs, input bit poke);
    int cyc;
    expect_slot(nid, ns, m0, mcs);
    a_done_seen = 0; b_done_seen = 0; a_nvalid = 0;
    issue(nid, ns, m0, mcs);
    chk("a_load", int'(a_load), 1);
    chk("a_init", int'(a_init), nid);
    chk("b_load", int'(b_load), 1);
    chk("b_init", int'(b_init), nid);
    chk("a_busy_load", int'(a_busy), 1);
    @(negedge clk);
    chk("a_load_one_cycle", int'(a_load), 0);
    chk("b_load_one_cycle", int'(b_load), 0);
    if (poke) begin
      for (cyc = 0; cyc < 5000 && a_nvalid < 3; cyc++) @(negedge clk);
      chk("poke_reached_collect", int'(a_nvalid >= 3), 1);
      issue(nid ^ 1, 0, 1, 1);
      chk("a_no_reload", int'(a_load), 0);
      chk("b_no_reload", int'(b_load), 0);
    end
    for (cyc = 0; cyc < 40000 && !(a_done_seen && b_done_seen); cyc++) @(negedge clk);
    chk("run_finished", int'(a_done_seen && b_done_seen), 1);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    chk("a_words_consumed", a_cons, 14 * (ns + 1));
    chk("b_bits_consumed", b_cons, 112 * (ns + 1));
    qa.delete(); qb.delete();
  endtask

  task automatic err_case(input int ns, input int m0, input int mcs);
    issue(5, ns, m0, mcs);
    chk("a_err_pulse", int'(a_err), 1);
    chk("b_err_pulse", int'(b_err), 1);
    chk("a_err_no_load", int'(a_load), 0);
    @(negedge clk);
    chk("a_err_one_cycle", int'(a_err), 0);
    chk("a_err_no_load2", int'(a_load | b_load | a_busy | b_busy), 0);
  endtask

  task automatic abort_case();
    int cyc;
    expect_slot(512, 3, 0, 0);
    issue(512, 3, 0, 0);
    for (cyc = 0; cyc < 5000 && !(a_valid && a_sym == 4'd5); cyc++) @(negedge clk);
    chk("abort_reached_l5", int'(a_valid && a_sym == 4'd5), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_a_en", int'(a_en), 0);
    chk("abort_a_valid", int'(a_valid), 0);
    chk("abort_a_busy", int'(a_busy), 0);
    chk("abort_b_en_busy", int'(b_en | b_busy), 0);
    rst = 1'b0;
    qa.delete(); qb.delete();
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0;
    i_nid = '0; i_nslot = '0; i_m0 = '0; i_mcs = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_init", int'(a_init), 0);
    chk("rst_a_flags", int'({a_en, a_load, a_valid, a_busy, a_done, a_err}), 0);
    chk("rst_a_data", int'({a_ncs, a_cs, a_sym}), 0);
    chk("rst_b_flags", int'({b_en, b_load, b_valid, b_busy, b_done, b_err}), 0);
    chk("rst_b_data", int'({b_init, b_ncs, b_cs, b_sym} != 0), 0);
    rst = 1'b0;

    run(512, 3, 0, 0, 0);
    run(100, 2, int'($urandom_range(11)), int'($urandom_range(11)), 0);
    run(512, 0, 5, 7, 0);
    ff_mode = 1'b1;
    run(77, 1, 11, 11, 0);
    ff_mode = 1'b0;
    err_case(160, 0, 0);
    err_case(3, 12, 0);
    err_case(3, 0, 12);
    abort_case();
    run(512, 3, 0, 0, 0);
    run(300, 2, 3, 4, 1);
    for (int k = 0; k < 5; k++)
      run(int'($urandom_range(1023)), int'($urandom_range(6)),
          int'($urandom_range(11)), int'($urandom_range(11)), 0);
    stall_pct = 0;
    run(1023, 159, 11, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pucch_cs_hop_gen.md
Name: pucch_cs_hop_gen

Overview:
- Sequence controller and consumer placed directly downstream of c_seq_gen in the PUCCH chain.
- Loads c_seq_gen with c_init = n_ID and discards the PRBS bits that belong to earlier slots.
- Packs 8 bits per OFDM symbol into n_cs(n_s,l) per TS 38.211 6.3.2.2.2, for l = 0..nSlotSymb-1.
- Emits n_cs and the cyclic-shift index (m0 + m_cs + n_cs) mod 12 to the low-PAPR sequence stage.

Parameters:
- nGenBit, 8: PRBS bits per c_seq_gen word. Only 1 or 8 are legal; must match the instantiated c_seq_gen.
- nSlotSymb, 14: symbols per slot.
- MaxSlot, 159: largest legal i_nslot.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_start  in  1  one-cycle request; samples i_nid, i_nslot, i_m0, i_mcs
- i_nid  in  10  hopping ID n_ID (c_init)
- i_nslot  in  8  slot number n_s
- i_m0  in  4  initial cyclic shift m0 (0..11)
- i_mcs  in  4  m_cs (0..11)
- o_prbs_en  out  1  to c_seq_gen i_en
- o_prbs_load  out  1  to c_seq_gen i_load
- o_prbs_init  out  31  to c_seq_gen i_init
- i_prbs_bit  in  nGenBit  from c_seq_gen o_seq_bit
- i_prbs_valid  in  1  from c_seq_gen o_valid
- o_ncs  out  8  n_cs for current symbol
- o_cs_idx  out  4  (m0 + m_cs + n_cs) mod 12
- o_sym_idx  out  4  symbol index l
- o_valid  out  1  o_ncs/o_cs_idx/o_sym_idx qualifier (strobe)
- o_busy  out  1  high from LOAD to COLLECT end
- o_done  out  1  one-cycle pulse after last symbol
- o_err  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset: state IDLE; every output 0 (including o_prbs_init); all counters 0. Reset mid-run aborts immediately and drops o_prbs_en the same edge.
- Bit order: word k carries c(nGenBit*k + j) on bit j, i.e. a word is consumed only when i_prbs_valid=1 and the first valid word after load is c(0).
- Packing: n_cs bit m = c(8*nSlotSymb*n_s + 8*l + m).
  - nGenBit=8: n_cs = word.
  - nGenBit=1: shift register ncs <= {bit, ncs[7:1]}; complete after 8 valid bits.
- FSM:
  - IDLE: on i_start, latch inputs. If i_nslot > MaxSlot, or i_m0 > 11, or i_mcs > 11: pulse o_err next cycle and stay IDLE. Otherwise go to LOAD.
  - LOAD (1 cycle): o_prbs_load=1, o_prbs_en=1, o_prbs_init = {21'b0, nid}. Clear skip counter, bit counter and symbol counter.
  - SKIP: o_prbs_en=1. Count valid words until 8*nSlotSymb*n_s/nGenBit have been discarded (15-bit counter; max 17808 bits). Then go to COLLECT.
  - n_s = 0: SKIP is bypassed; LOAD goes straight to COLLECT.
  - COLLECT: o_prbs_en=1. On each completed byte, register outputs the next cycle: o_valid=1, o_ncs, o_sym_idx=l, o_cs_idx. Increment l.
  - Leaving COLLECT: after l = nSlotSymb-1 is emitted, drop o_prbs_en the same edge and go to DONE. No extra PRBS words are consumed.
  - DONE (1 cycle): o_done=1, o_busy=0. Return to IDLE.
- Latency: one output per 8/nGenBit valid words. o_valid follows the completing valid word by exactly 1 clk.
- i_prbs_valid low stalls all counting. No timeout.
- i_start while o_busy=1 is ignored. No queueing and no error.
- Arithmetic: s = m0 + mcs + ncs is 9 bits (max 277). o_cs_idx = s mod 12, computed combinationally before the output register.
- o_ncs, o_cs_idx and o_sym_idx hold their last values while o_valid=0. Reset clears them.

Test Plan:
- nid=512, nslot=3, nGenBit=8, m0=0, mcs=0, real c_seq_gen: exactly 42 valid words skipped, then 14 o_valid pulses with l=0..13. o_ncs matches the Matlab nrPRBS(512, 112*4) bytes 42..55. o_cs_idx = o_ncs mod 12. o_done one cycle after l=13.
- nid=100, nslot=2, nGenBit=1: 224 bits skipped; 14 bytes match nrPRBS(100, 336) bits 224..335, LSB = first bit; 112 bits consumed in COLLECT.
- nid=512, nslot=0: first valid word is n_cs(0); o_prbs_load high exactly one cycle with o_prbs_init=512.
- Behavioural PRBS driver supplying 0xFF words, m0=11, mcs=11: o_ncs=255, o_cs_idx=1. The driver also toggles i_prbs_valid 1-0-0-1, and outputs must appear only after valid words.
- i_nslot=160 -> o_err pulse, o_prbs_load never asserted. i_m0=12 -> o_err.
- rst asserted at l=5 -> next cycle o_prbs_en=0, o_valid=0, o_busy=0. A subsequent i_start (nslot=3) reproduces the full 14-symbol result of the first scenario. i_start pulsed mid-COLLECT is ignored.
